// File: rtl/biquad_coeff_sequencer.sv
// Coefficient sequencer for a biquad cascade: a host-filled shadow memory is
// replayed as back-to-back per-stage writes, then one broadcast update pulse.
module biquad_coeff_sequencer #(
    parameter int NSTAGE = 2,
    parameter int CBITS  = 18,
    parameter int N_FIR0 = 3,
    parameter int N_FIR1 = 4,
    parameter int N_IIR  = 4,
    parameter int N_INCR = 6,
    localparam int W     = N_FIR0 + N_FIR1 + N_IIR + N_INCR,
    localparam int AW    = $clog2(NSTAGE * W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     host_adr_i,
    input  logic [CBITS-1:0]  host_dat_i,
    input  logic              host_wr_i,
    input  logic              host_commit_i,
    input  logic [NSTAGE-1:0] stage_mask_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CBITS-1:0]  coeff_dat_o,
    output logic [1:0]        coeff_adr_o,
    output logic [NSTAGE-1:0] fir_wr_o,
    output logic [NSTAGE-1:0] iir_wr_o,
    output logic [NSTAGE-1:0] incr_wr_o,
    output logic              coeff_update_o
);

    localparam int NW = NSTAGE * W;
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam logic [AW-1:0] W_A = AW'(W);
    localparam logic [WW-1:0] LAST_W = WW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     stg_q, stg_d;
    logic [WW-1:0]     wrd_q, wrd_d;
    logic [NSTAGE-1:0] mask_q, mask_d;
    logic              err_q, err_d;
    logic              vld_q, vld_d;
    logic [SW-1:0]     pstg_q, pstg_d;
    logic [WW-1:0]     pwrd_q, pwrd_d;
    logic [CBITS-1:0]  rdata_q;
    logic [CBITS-1:0]  shadow_mem [NW];

    logic          idle;
    logic          wr_ok;
    logic [AW-1:0] rd_adr;
    logic [SW-1:0] first_stg;
    logic [SW-1:0] nxt_stg;
    logic          nxt_found;

    assign idle   = (state_q == S_IDLE);
    assign wr_ok  = host_wr_i && idle && (int'(host_adr_i) < NW);
    assign rd_adr = AW'(stg_q) * W_A + AW'(wrd_q);

    // Shadow memory is deliberately unreset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            shadow_mem[host_adr_i] <= host_dat_i;
        end
        rdata_q <= shadow_mem[rd_adr];
    end

    always_comb begin
        first_stg = '0;
        nxt_stg   = '0;
        nxt_found = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (stage_mask_i[i]) begin
                first_stg = SW'(i);
            end
            if (mask_q[i] && (SW'(i) > stg_q)) begin
                nxt_stg   = SW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        wrd_d   = wrd_q;
        mask_d  = mask_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        pstg_d  = stg_q;
        pwrd_d  = wrd_q;
        if (host_wr_i && !wr_ok) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (host_commit_i) begin
                    err_d   = host_wr_i && !wr_ok;
                    mask_d  = stage_mask_i;
                    stg_d   = first_stg;
                    wrd_d   = '0;
                    state_d = (|stage_mask_i) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                vld_d = 1'b1;
                if (wrd_q == LAST_W) begin
                    wrd_d = '0;
                    if (nxt_found) begin
                        stg_d = nxt_stg;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    wrd_d = wrd_q + 1'b1;
                end
            end
            // One drain cycle lets the last memory read reach the bus.
            S_FLUSH:  state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (host_commit_i && !idle) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stg_q   <= '0;
            wrd_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            pstg_q  <= '0;
            pwrd_q  <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            wrd_q   <= wrd_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            pstg_q  <= pstg_d;
            pwrd_q  <= pwrd_d;
        end
    end

    logic              is_fir;
    logic              is_a1;
    logic              is_iir;
    logic [NSTAGE-1:0] oh;

    always_comb begin
        is_fir = pwrd_q < WW'(N_FIR0 + N_FIR1);
        is_a1  = is_fir && (pwrd_q >= WW'(N_FIR0));
        is_iir = !is_fir && (pwrd_q < WW'(N_FIR0 + N_FIR1 + N_IIR));
        oh     = vld_q ? (NSTAGE'(1) << pstg_q) : '0;
    end

    assign fir_wr_o       = is_fir ? oh : '0;
    assign iir_wr_o       = is_iir ? oh : '0;
    assign incr_wr_o      = (!is_fir && !is_iir) ? oh : '0;
    assign coeff_adr_o    = {1'b0, vld_q & is_a1};
    assign coeff_dat_o    = vld_q ? rdata_q : '0;
    assign busy_o         = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                            (state_q == S_UPDATE);
    assign done_o         = (state_q == S_UPDATE) || (state_q == S_DONE);
    assign coeff_update_o = (state_q == S_UPDATE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Randomized bench for biquad_coeff_sequencer: a shadow-array model predicts
// every cycle of each replay, compared on the falling clock edge.
module tb_biquad_coeff_sequencer;

    localparam int NSTAGE = 2;
    localparam int CBITS  = 18;
    localparam int N_FIR0 = 3;
    localparam int N_FIR1 = 4;
    localparam int N_IIR  = 4;
    localparam int N_INCR = 6;
    localparam int W      = N_FIR0 + N_FIR1 + N_IIR + N_INCR;
    localparam int NW     = NSTAGE * W;
    localparam int AW     = $clog2(NW);
    localparam int VW     = 4 + 3 * NSTAGE + 2 + CBITS;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     host_adr_i;
    logic [CBITS-1:0]  host_dat_i;
    logic              host_wr_i;
    logic              host_commit_i;
    logic [NSTAGE-1:0] stage_mask_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [CBITS-1:0]  coeff_dat_o;
    logic [1:0]        coeff_adr_o;
    logic [NSTAGE-1:0] fir_wr_o;
    logic [NSTAGE-1:0] iir_wr_o;
    logic [NSTAGE-1:0] incr_wr_o;
    logic              coeff_update_o;

    biquad_coeff_sequencer #(
        .NSTAGE(NSTAGE), .CBITS(CBITS), .N_FIR0(N_FIR0),
        .N_FIR1(N_FIR1), .N_IIR(N_IIR), .N_INCR(N_INCR)
    ) dut (
        .clk(clk), .rst(rst),
        .host_adr_i(host_adr_i), .host_dat_i(host_dat_i),
        .host_wr_i(host_wr_i), .host_commit_i(host_commit_i),
        .stage_mask_i(stage_mask_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .coeff_dat_o(coeff_dat_o), .coeff_adr_o(coeff_adr_o),
        .fir_wr_o(fir_wr_o), .iir_wr_o(iir_wr_o), .incr_wr_o(incr_wr_o),
        .coeff_update_o(coeff_update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CBITS-1:0] sh [NW];
    logic model_err = 1'b0;

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] obs();
        return {busy_o, done_o, coeff_update_o, err_o, fir_wr_o, iir_wr_o,
                incr_wr_o, coeff_adr_o, coeff_dat_o};
    endfunction

    function automatic logic [VW-1:0] mk(input logic b, input logic d,
                                         input logic u, input int kind,
                                         input int s, input logic [1:0] adr,
                                         input logic [CBITS-1:0] dat);
        logic [NSTAGE-1:0] oh, f, i, n;
        oh = (kind != 0) ? (NSTAGE'(1) << s) : '0;
        f  = (kind == 1) ? oh : '0;
        i  = (kind == 2) ? oh : '0;
        n  = (kind == 3) ? oh : '0;
        return {b, d, u, 1'b0, f, i, n, adr, dat};
    endfunction

    task automatic hw(input int adr, input logic [CBITS-1:0] dat);
        @(negedge clk);
        host_wr_i  = 1'b1;
        host_adr_i = AW'(adr);
        host_dat_i = dat;
        @(posedge clk);
        #1 host_wr_i = 1'b0;
        if (adr < NW) sh[adr] = dat;
        else model_err = 1'b1;
    endtask

    task automatic run(input logic [NSTAGE-1:0] mask, input int inj,
                       input int rst_c, input string tag);
        logic [VW-1:0] q[$];
        logic [VW-1:0] exp;
        logic e;
        int kind;
        logic [1:0] adr;
        if (mask == 0) begin
            q.push_back(mk(0, 1, 0, 0, 0, 2'd0, '0));
        end else begin
            q.push_back(mk(1, 0, 0, 0, 0, 2'd0, '0));
            for (int s = 0; s < NSTAGE; s++) begin
                if (!mask[s]) continue;
                for (int w = 0; w < W; w++) begin
                    adr = 2'd0;
                    if (w < N_FIR0) kind = 1;
                    else if (w < N_FIR0 + N_FIR1) begin
                        kind = 1;
                        adr  = 2'd1;
                    end else if (w < N_FIR0 + N_FIR1 + N_IIR) kind = 2;
                    else kind = 3;
                    q.push_back(mk(1, 0, 0, kind, s, adr, sh[s*W+w]));
                end
            end
            q.push_back(mk(1, 1, 1, 0, 0, 2'd0, '0));
        end
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, '0));
        @(negedge clk);
        host_commit_i = 1'b1;
        stage_mask_i  = mask;
        @(posedge clk);
        e = 1'b0;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            host_commit_i = 1'b0;
            host_wr_i     = 1'b0;
            exp = q[c-1];
            exp[VW-4] = e;
            chk($sformatf("%s c%0d", tag, c), obs(), exp);
            if (c == rst_c) begin
                rst = 1'b1;
                #1 chk($sformatf("%s rst_async", tag), obs(), '0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s rst_hold%0d", tag, k), obs(), '0);
                end
                rst = 1'b0;
                model_err = 1'b0;
                return;
            end
            if (c == inj) begin
                host_wr_i     = 1'b1;
                host_adr_i    = AW'(5);
                host_dat_i    = '1;
                host_commit_i = 1'b1;
                stage_mask_i  = ~mask;
                e = 1'b1;
            end
        end
        model_err = e;
    endtask

    initial begin
        int m, k, inj, n;
        rst = 1'b1;
        host_adr_i = '0;
        host_dat_i = '0;
        host_wr_i = 1'b0;
        host_commit_i = 1'b0;
        stage_mask_i = '0;
        #1 chk("reset", obs(), '0);
        repeat (2) @(negedge clk);
        chk("reset_hold", obs(), '0);
        rst = 1'b0;

        for (int a = 0; a < W; a++) hw(a, CBITS'(a + 1));
        chk("err_idle", {{(VW-1){1'b0}}, err_o}, '0);
        run(2'b01, 0, 0, "s1");

        for (int a = 0; a < NW; a++) hw(a, CBITS'(a + 1));
        run(2'b11, 0, 0, "s2");
        run(2'b00, 0, 0, "s3");

        run(2'b01, 6, 0, "s4_inj");
        chk("s4_err", {{(VW-1){1'b0}}, err_o}, VW'(1));
        run(2'b01, 0, 0, "s4_re");

        hw(34, 18'h15555);
        chk("oor_err", {{(VW-1){1'b0}}, err_o}, {{(VW-1){1'b0}}, model_err});
        run(2'b11, 0, 0, "s5");

        run(2'b01, 0, 10, "s6");
        run(2'b01, 0, 0, "s6_post");

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                hw($urandom_range(0, 40), CBITS'($urandom));
            end
            chk($sformatf("rnd%0d err", it), {{(VW-1){1'b0}}, err_o},
                {{(VW-1){1'b0}}, model_err});
            m = $urandom_range(0, 3);
            k = $countones(m);
            inj = 0;
            if (k != 0 && $urandom_range(0, 1) == 1) begin
                inj = $urandom_range(1, k * W + 2);
            end
            run(NSTAGE'(m), inj, 0, $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
